// File: rtl/odo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : odo_pkg
//  Description : Shared widths and lane-offset helpers for the Odo
//                substitution layer.
//  Revision    : 1.0 - initial release
// ============================================================================
package odo_pkg;

    localparam int SMALL_W     = 6;
    localparam int LARGE_W     = 10;
    localparam int N_SMALL     = 4;
    localparam int N_LARGE     = 4;
    localparam int ODO_WORDS   = 10;
    localparam int SMALL_BUS_W = SMALL_W * N_SMALL;
    localparam int LARGE_BUS_W = LARGE_W * N_LARGE;
    localparam int WORD_W      = SMALL_BUS_W + LARGE_BUS_W;
    localparam int IDX_W       = 4;

    // Bit offset of small lane k within a 64-bit state word.
    function automatic int small_lo(input int k);
        return k * SMALL_W;
    endfunction

    // Large lanes sit above the packed small lanes.
    function automatic int large_lo(input int k);
        return SMALL_BUS_W + k * LARGE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/odo_fwft_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : odo_fwft_fifo
//  Description : First-word-fall-through FIFO; head entry is always on rd_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module odo_fwft_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is only taken when the head leaves the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/odo_sbox_word_sched.sv
`default_nettype none
// ============================================================================
//  Module      : odo_sbox_word_sched
//  Description : Splits state words into S-box lanes, tracks results through
//                the fixed-latency S-boxes and buffers them in a credited FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module odo_sbox_word_sched
    import odo_pkg::*;
#(
    parameter int SBOX_LAT   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int WORDS      = ODO_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_W-1:0]      in_data,
    output logic [SMALL_BUS_W-1:0] sbox_small_in,
    input  logic [SMALL_BUS_W-1:0] sbox_small_out,
    output logic [LARGE_BUS_W-1:0] sbox_large_in,
    input  logic [LARGE_BUS_W-1:0] sbox_large_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last
);

    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_SUM_W   = $clog2(FIFO_DEPTH + SBOX_LAT + 2);
    localparam int c_ENTRY_W = WORD_W + IDX_W;

    logic [WORD_W-1:0]    r_in_data;
    logic [SBOX_LAT:0]    r_pipe_vld;
    logic [IDX_W-1:0]     r_pipe_idx [SBOX_LAT+1];
    logic [IDX_W-1:0]     r_idx;
    logic                 w_accept;
    logic [c_SUM_W-1:0]   w_inflight;
    logic [c_SUM_W-1:0]   w_used;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    logic [WORD_W-1:0]    w_word_out;
    logic [c_ENTRY_W-1:0] w_fifo_rd;

    // Credits come only from registers, so out_ready never reaches in_ready.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= SBOX_LAT; i++) begin
            w_inflight = w_inflight + c_SUM_W'(r_pipe_vld[i]);
        end
    end

    assign w_used   = c_SUM_W'(w_fifo_count) + w_inflight;
    assign in_ready = (w_used < c_SUM_W'(FIFO_DEPTH));
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_data <= '0;
        end else if (w_accept) begin
            r_in_data <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_accept) begin
            if (r_idx == IDX_W'(WORDS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Stage 0 of this pipe lines up with r_in_data; the tail lines up with
    // the registered S-box results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i <= SBOX_LAT; i++) begin
                r_pipe_idx[i] <= '0;
            end
        end else begin
            r_pipe_vld    <= {r_pipe_vld[SBOX_LAT-1:0], w_accept};
            r_pipe_idx[0] <= r_idx;
            for (int i = 1; i <= SBOX_LAT; i++) begin
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
        end
    end

    for (genvar k = 0; k < N_SMALL; k++) begin : g_small_lane
        assign sbox_small_in[k*SMALL_W +: SMALL_W]   = r_in_data[small_lo(k) +: SMALL_W];
        assign w_word_out[small_lo(k) +: SMALL_W]     = sbox_small_out[k*SMALL_W +: SMALL_W];
    end

    for (genvar k = 0; k < N_LARGE; k++) begin : g_large_lane
        assign sbox_large_in[k*LARGE_W +: LARGE_W]   = r_in_data[large_lo(k) +: LARGE_W];
        assign w_word_out[large_lo(k) +: LARGE_W]     = sbox_large_out[k*LARGE_W +: LARGE_W];
    end

    odo_fwft_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (r_pipe_vld[SBOX_LAT]),
        .wr_data ({r_pipe_idx[SBOX_LAT], w_word_out}),
        .pop     (w_pop),
        .rd_data (w_fifo_rd),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    assign out_valid = ~w_fifo_empty;
    assign w_pop     = out_valid & out_ready;
    assign out_data  = w_fifo_rd[WORD_W-1:0];
    assign out_idx   = w_fifo_rd[c_ENTRY_W-1 -: IDX_W];
    assign out_last  = (out_idx == IDX_W'(WORDS - 1));

    a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_pipe_vld[SBOX_LAT] && w_fifo_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_odo_sbox_word_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_odo_sbox_word_sched
//  Description : Directed and randomised self-checking bench for the
//                Odo S-box word scheduler with registered S-box models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_odo_sbox_word_sched;

    localparam int SBOX_LAT   = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int WORDS      = 10;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [23:0] sbox_small_in;
    logic [23:0] sbox_small_out;
    logic [39:0] sbox_large_in;
    logic [39:0] sbox_large_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;

    int n_checks;
    int n_errors;

    odo_sbox_word_sched #(
        .SBOX_LAT   (SBOX_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WORDS      (WORDS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .sbox_small_in  (sbox_small_in),
        .sbox_small_out (sbox_small_out),
        .sbox_large_in  (sbox_large_in),
        .sbox_large_out (sbox_large_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_idx        (out_idx),
        .out_last       (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the small S-box: matches its values at 0 (->38) and 63 (->14).
    function automatic logic [5:0] sbox6(input logic [5:0] x);
        if (x == 6'd63) return 6'd14;
        return 6'((int'(x) * 13 + 38) % 64);
    endfunction

    function automatic logic [63:0] exp_word(input logic [63:0] d);
        logic [63:0] r;
        r = d;
        for (int k = 0; k < 4; k++) begin
            r[6*k +: 6] = sbox6(d[6*k +: 6]);
        end
        return r;
    endfunction

    // Registered S-box banks, one clock of latency.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            sbox_small_out[6*k +: 6] <= sbox6(sbox_small_in[6*k +: 6]);
        end
        sbox_large_out <= sbox_large_in;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        n_checks++;
        if (out_idx !== 4'd0 || out_last !== 1'b0 || out_data !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: idx=%0d last=%b data=%h want 0 0 0", out_idx, out_last, out_data);
        end
        n_checks++;
        if (sbox_small_in !== 24'd0 || sbox_large_in !== 40'd0) begin
            n_errors++;
            $display("FAIL reset_sbox_in: small=%h large=%h want 0 0", sbox_small_in, sbox_large_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single(input string tag, input logic [63:0] d,
                               input logic [63:0] expd, input logic [3:0] idx);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_ready: in_ready=%b want 1", tag, in_ready);
        end
        in_valid = 1'b1; in_data = d; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || sbox_small_in !== d[23:0] || sbox_large_in !== d[63:24]) begin
            n_errors++;
            $display("FAIL %s_stage0: valid=%b small=%h large=%h want 0 %h %h",
                     tag, out_valid, sbox_small_in, sbox_large_in, d[23:0], d[63:24]);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_early: out_valid=%b want 0", tag, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== expd || out_idx !== idx || out_last !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_out: valid=%b data=%h idx=%0d last=%b want 1 %h %0d 0",
                     tag, out_valid, out_data, out_idx, out_last, expd, idx);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== expd) begin
            n_errors++;
            $display("FAIL %s_hold: valid=%b data=%h want 1 %h", tag, out_valid, out_data, expd);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_pop: out_valid=%b want 0", tag, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] words [11];
        int got;
        int first_cyc;
        do_reset();
        for (int i = 0; i < 11; i++) words[i] = {$urandom, $urandom};
        out_ready = 1'b1;
        got = 0;
        first_cyc = -1;
        fork
            begin
                for (int i = 0; i < 11; i++) begin
                    @(negedge clk);
                    n_checks++;
                    if (in_ready !== 1'b1) begin
                        n_errors++;
                        $display("FAIL b2b_in_ready: word %0d in_ready=%b want 1", i, in_ready);
                    end
                    in_valid = 1'b1; in_data = words[i];
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 30 && got < 11; c++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) begin
                        if (first_cyc < 0) first_cyc = c;
                        n_checks++;
                        if (c != first_cyc + got || out_data !== exp_word(words[got]) ||
                            out_idx !== 4'(got % WORDS) ||
                            out_last !== ((got % WORDS == WORDS - 1) ? 1'b1 : 1'b0)) begin
                            n_errors++;
                            $display("FAIL b2b_out%0d: cyc=%0d data=%h idx=%0d last=%b want cyc=%0d %h %0d",
                                     got, c, out_data, out_idx, out_last, first_cyc + got,
                                     exp_word(words[got]), got % WORDS);
                        end
                        got++;
                    end
                end
            end
        join
        n_checks++;
        if (got != 11 || first_cyc != 3) begin
            n_errors++;
            $display("FAIL b2b_count: got=%0d first_cyc=%0d want 11 3", got, first_cyc);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] words [8];
        int n_acc;
        int got;
        do_reset();
        for (int i = 0; i < 8; i++) words[i] = {$urandom, $urandom};
        out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = words[n_acc];
            if (in_ready === 1'b1 && n_acc < 7) n_acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (n_acc != FIFO_DEPTH || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_accepted: accepted=%0d in_ready=%b want %0d 0", n_acc, in_ready, FIFO_DEPTH);
        end
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_word(words[0]) || out_idx !== 4'd0) begin
                n_errors++;
                $display("FAIL bp_hold: valid=%b data=%h idx=%0d want 1 %h 0",
                         out_valid, out_data, out_idx, exp_word(words[0]));
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid === 1'b1) begin
                n_checks++;
                if (got >= n_acc) begin
                    n_errors++;
                    $display("FAIL bp_extra: unexpected word data=%h idx=%0d want none", out_data, out_idx);
                end else if (out_data !== exp_word(words[got]) || out_idx !== 4'(got)) begin
                    n_errors++;
                    $display("FAIL bp_drain%0d: data=%h idx=%0d want %h %0d",
                             got, out_data, out_idx, exp_word(words[got]), got);
                end
                got++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != FIFO_DEPTH || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_drained: got=%0d in_ready=%b want %0d 1", got, in_ready, FIFO_DEPTH);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [67:0] q [$];
        logic [67:0] head;
        logic [3:0]  idx;
        int acc;
        int popped;
        int occ;
        do_reset();
        acc = 0; popped = 0; idx = 4'd0;
        for (int c = 0; c < 20000 && popped < 1000; c++) begin
            @(negedge clk);
            occ = acc - popped;
            n_checks++;
            if (in_ready !== ((occ < FIFO_DEPTH) ? 1'b1 : 1'b0) || occ > FIFO_DEPTH) begin
                n_errors++;
                $display("FAIL rnd_credit: cyc=%0d in_ready=%b occupancy=%0d want ready=%0d", c, in_ready, occ,
                         (occ < FIFO_DEPTH) ? 1 : 0);
            end
            out_ready = ($urandom_range(0, 1) == 1);
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rnd_spurious: data=%h idx=%0d want no word", out_data, out_idx);
                end else begin
                    head = q.pop_front();
                    if ({out_idx, out_data} !== head ||
                        out_last !== ((head[67:64] == 4'(WORDS - 1)) ? 1'b1 : 1'b0)) begin
                        n_errors++;
                        $display("FAIL rnd_word%0d: idx=%0d data=%h last=%b want %0d %h",
                                 popped, out_idx, out_data, out_last, head[67:64], head[63:0]);
                    end
                end
                popped++;
            end
            in_valid = (acc < 1000) && ($urandom_range(0, 1) == 1);
            if (in_valid) begin
                in_data = {$urandom, $urandom};
                if (in_ready === 1'b1) begin
                    q.push_back({idx, exp_word(in_data)});
                    idx = (idx == 4'(WORDS - 1)) ? 4'd0 : idx + 4'd1;
                    acc++;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (popped != 1000 || q.size() != 0) begin
            n_errors++;
            $display("FAIL rnd_total: popped=%0d left=%0d want 1000 0", popped, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] w;
        int got;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL mid_fill: word %0d in_ready=%b want 1", i, in_ready);
            end
            in_valid = 1'b1; in_data = {$urandom, $urandom};
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_state: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 4'd0) begin
            n_errors++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b idx=%0d want 0 1 0", out_valid, in_ready, out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        w = {$urandom, $urandom};
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = w;
        @(negedge clk);
        in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n_checks++;
                if (got > 0 || out_data !== exp_word(w) || out_idx !== 4'd0) begin
                    n_errors++;
                    $display("FAIL mid_after%0d: data=%h idx=%0d want single %h 0", got, out_data, out_idx, exp_word(w));
                end
                got++;
            end
        end
        n_checks++;
        if (got != 1) begin
            n_errors++;
            $display("FAIL mid_count: outputs=%0d want 1", got);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single("zero", 64'h0, 64'h0000_0000_009A_69A6, 4'd0);
        test_single("ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FF38_E38E, 4'd1);
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
